// File: rtl/vsm_pkg.sv
// vsm_pkg: shared types and default widths for the VSM output serializer.
// Optional build macro used by the serializer: VSM_TX_PARITY_EN.
package vsm_pkg;

   localparam int VSM_DATA_W   = 4;
   localparam int VSM_TX_DEPTH = 4;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

endpackage

// File: rtl/vsm_out_serializer_if.sv
// vsm_out_serializer_if: output-register word feed plus serial line status.
// master = producer/observer side, slave = serializer side.
interface vsm_out_serializer_if
   import vsm_pkg::*;
#(
   parameter int DATA_W = VSM_DATA_W,
   parameter int DEPTH  = VSM_TX_DEPTH
);

   logic [DATA_W-1:0]       OutData;
   logic                    OutLoad;
   logic                    TxLine;
   logic                    TxBusy;
   logic [$clog2(DEPTH):0]  FifoCount;
   logic                    Overflow;

   modport master (
      output OutData,
      output OutLoad,
      input  TxLine,
      input  TxBusy,
      input  FifoCount,
      input  Overflow
   );

   modport slave (
      input  OutData,
      input  OutLoad,
      output TxLine,
      output TxBusy,
      output FifoCount,
      output Overflow
   );

endinterface

// File: rtl/vsm_tx_fifo.sv
// vsm_tx_fifo: synchronous FIFO of DEPTH x DATA_W registers.
// A push on a full FIFO succeeds only when a pop happens at the same edge.
module vsm_tx_fifo
   import vsm_pkg::*;
#(
   parameter int DATA_W = VSM_DATA_W,
   parameter int DEPTH  = VSM_TX_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_W-1:0]      din,
   output logic [DATA_W-1:0]      dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers wrap mod DEPTH; count tracks occupancy and never exceeds DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vsm_out_serializer.sv
// vsm_out_serializer: queues output-register words and sends them UART-style.
// Define VSM_TX_PARITY_EN to add an even-parity bit between data and stop.
module vsm_out_serializer
   import vsm_pkg::*;
#(
   parameter int DATA_W   = VSM_DATA_W,
   parameter int DEPTH    = VSM_TX_DEPTH,
   parameter int BAUD_DIV = 4
) (
   input  logic MainClock,
   input  logic MainReset,
   vsm_out_serializer_if.slave bus
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

   tx_state_t         state;
   tx_state_t         state_n;
   logic [CW-1:0]     baud_cnt;
   logic [BW-1:0]     bit_idx;
   logic [DATA_W-1:0] shift_q;
   logic              ovf_q;
   logic              baud_tick;
   logic              pop;
   logic              full;
   logic              empty;
   logic [DATA_W-1:0] head;
   logic              tx_line;
`ifdef VSM_TX_PARITY_EN
   logic              par_q;
`endif

   vsm_tx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (MainClock),
      .rst   (MainReset),
      .push  (bus.OutLoad),
      .pop   (pop),
      .din   (bus.OutData),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (bus.FifoCount)
   );

   assign baud_tick = (state != IDLE) && (baud_cnt == BAUD_LAST);

   // State register.
   always_ff @(posedge MainClock) begin
      if (MainReset) state <= IDLE;
      else           state <= state_n;
   end

   // Next state, FIFO pop request and line level.
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      tx_line = 1'b1;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_n = START;
            end
         end
         START: begin
            tx_line = 1'b0;
            if (baud_tick) state_n = DATA;
         end
         DATA: begin
            tx_line = shift_q[0];
            if (baud_tick && (bit_idx == BIT_LAST)) begin
`ifdef VSM_TX_PARITY_EN
               state_n = PARITY;
`else
               state_n = STOP;
`endif
            end
         end
         PARITY: begin
`ifdef VSM_TX_PARITY_EN
            tx_line = par_q;
            if (baud_tick) state_n = STOP;
`else
            state_n = IDLE;
`endif
         end
         STOP: begin
            if (baud_tick) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Baud counter, bit index and shift register.
   always_ff @(posedge MainClock) begin
      if (MainReset) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift_q  <= '0;
`ifdef VSM_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         if ((state == IDLE) || baud_tick) baud_cnt <= '0;
         else                              baud_cnt <= baud_cnt + 1'b1;
         if (pop) begin
            shift_q <= head;
            bit_idx <= '0;
`ifdef VSM_TX_PARITY_EN
            par_q   <= ^head;
`endif
         end else if ((state == DATA) && baud_tick) begin
            shift_q <= shift_q >> 1;
            bit_idx <= bit_idx + 1'b1;
         end
      end
   end

   // Sticky flag: a strobe arrived while full with no pop to make room.
   always_ff @(posedge MainClock) begin
      if (MainReset)                         ovf_q <= 1'b0;
      else if (bus.OutLoad && full && !pop)  ovf_q <= 1'b1;
   end

   assign bus.TxLine   = tx_line;
   assign bus.TxBusy   = (state != IDLE);
   assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_vsm_out_serializer.sv
// tb_vsm_out_serializer: directed checks of framing, queueing and overflow.
// Honours VSM_TX_PARITY_EN for the expected frame shape.
module tb_vsm_out_serializer;

   localparam int B  = 4;
   localparam int DW = 4;
`ifdef VSM_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FRAME = (2 + DW + P) * B;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   vsm_out_serializer_if bus ();

   vsm_out_serializer dut (
      .MainClock (clk),
      .MainReset (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic line_at(input logic [3:0] w, input int k);
      int seg;
      seg = k / B;
      if (seg == 0)  return 1'b0;
      if (seg <= DW) return w[seg-1];
      if (P == 1 && seg == DW + 1) return ^w;
      return 1'b1;
   endfunction

   task automatic frame(input logic [3:0] w, input int k0, input int k1);
      for (int k = k0; k < k1; k++) begin
         check($sformatf("line w%0d k%0d", w, k),
               32'(bus.TxLine), 32'(line_at(w, k)));
         check($sformatf("busy w%0d k%0d", w, k),
               32'(bus.TxBusy), 1);
         step(1);
      end
   endtask

   task automatic idle_chk(input string tag, input int ovf);
      check({tag, " line"},  32'(bus.TxLine), 1);
      check({tag, " busy"},  32'(bus.TxBusy), 0);
      check({tag, " count"}, 32'(bus.FifoCount), 0);
      check({tag, " ovf"},   32'(bus.Overflow), 32'(ovf));
   endtask

   task automatic do_reset;
      rst         = 1'b1;
      bus.OutLoad = 1'b0;
      bus.OutData = '0;
      step(2);
      rst = 1'b0;
   endtask

   task automatic load(input logic [3:0] w);
      bus.OutData = w;
      bus.OutLoad = 1'b1;
      step(1);
      bus.OutLoad = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.OutLoad = 1'b0;
      bus.OutData = '0;

      // 1: reset held two cycles
      rst = 1'b1;
      step(2);
      idle_chk("reset", 0);
      rst = 1'b0;

      // 2: single word 1011
      load(4'b1011);
      check("t2 count", 32'(bus.FifoCount), 1);
      check("t2 busy0", 32'(bus.TxBusy), 0);
      check("t2 line0", 32'(bus.TxLine), 1);
      step(1);
      check("t2 count1", 32'(bus.FifoCount), 0);
      frame(4'b1011, 0, FRAME);
      idle_chk("t2 end", 0);

      // 3: five strobes, back-to-back frames
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         bus.OutData = 4'(i);
         bus.OutLoad = 1'b1;
         step(1);
      end
      bus.OutLoad = 1'b0;
      check("t3 count", 32'(bus.FifoCount), 4);
      check("t3 ovf", 32'(bus.Overflow), 0);
      frame(4'd1, 3, FRAME);
      for (int w = 2; w <= 5; w++) begin
         check($sformatf("t3 count w%0d", w), 32'(bus.FifoCount), 32'(5 - w));
         frame(4'(w), 0, FRAME);
      end
      idle_chk("t3 end", 0);

      // 4: six strobes, sixth dropped
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         bus.OutData = 4'(i);
         bus.OutLoad = 1'b1;
         step(1);
      end
      bus.OutLoad = 1'b0;
      check("t4 count", 32'(bus.FifoCount), 4);
      check("t4 ovf", 32'(bus.Overflow), 1);
      frame(4'd1, 4, FRAME);
      for (int w = 2; w <= 5; w++) begin
         check($sformatf("t4 ovf w%0d", w), 32'(bus.Overflow), 1);
         frame(4'(w), 0, FRAME);
      end
      idle_chk("t4 end", 1);
      step(3);
      check("t4 ovf sticky", 32'(bus.Overflow), 1);
      do_reset();
      check("t4 ovf reset", 32'(bus.Overflow), 0);

      // 5: push and pop at the same edge while full
      for (int i = 1; i <= 5; i++) begin
         bus.OutData = 4'(i);
         bus.OutLoad = 1'b1;
         step(1);
      end
      bus.OutLoad = 1'b0;
      frame(4'd1, 3, FRAME - 1);
      check("t5 full", 32'(bus.FifoCount), 4);
      bus.OutData = 4'd6;
      bus.OutLoad = 1'b1;
      frame(4'd1, FRAME - 1, FRAME);
      bus.OutLoad = 1'b0;
      check("t5 count", 32'(bus.FifoCount), 4);
      check("t5 ovf", 32'(bus.Overflow), 0);
      for (int w = 2; w <= 6; w++) begin
         check($sformatf("t5 count w%0d", w), 32'(bus.FifoCount), 32'(6 - w));
         frame(4'(w), 0, FRAME);
      end
      idle_chk("t5 end", 0);

      // 6: reset during data bit 2
      do_reset();
      bus.OutData = 4'b1011;
      bus.OutLoad = 1'b1;
      step(1);
      bus.OutData = 4'b0110;
      step(1);
      bus.OutLoad = 1'b0;
      check("t6 count", 32'(bus.FifoCount), 1);
      frame(4'b1011, 0, 13);
      rst = 1'b1;
      step(1);
      idle_chk("t6 abort", 0);
      rst = 1'b0;
      load(4'b0110);
      step(1);
      frame(4'b0110, 0, FRAME);
      idle_chk("t6 end", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
